// File: rtl/opb_snapshot_pkg.sv
// opb_snapshot_pkg: register map, CTRL bit positions and capture FSM
// states shared by the snapshot register bank and its bench.
package opb_snapshot_pkg;

   localparam logic [31:0] OFF_CTRL   = 32'h00;
   localparam logic [31:0] OFF_STATUS = 32'h04;
   localparam logic [31:0] OFF_CAPCNT = 32'h08;
   localparam logic [31:0] OFF_MISSED = 32'h0C;
   localparam logic [31:0] OFF_DATA   = 32'h10;

   localparam int CTRL_MODE = 31;
   localparam int CTRL_ARM  = 30;
   localparam int CTRL_CLR  = 29;

   localparam int MISSED_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ARMED    = 2'd1,
      ST_CAPTURED = 2'd2
   } state_t;

endpackage

// File: rtl/opb_slave_decode.sv
// opb_slave_decode: OPB slave front end with range check, one ack per
// select assertion and registered read data.
module opb_slave_decode #(
   parameter logic [31:0] C_BASEADDR = 32'hFFFF_FFFF,
   parameter logic [31:0] C_HIGHADDR = 32'h0000_0000,
   parameter int          C_DWIDTH   = 32
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [31:0]         i_addr,
   input  logic                i_select,
   input  logic                i_rnw,
   input  logic [C_DWIDTH-1:0] i_rdata,
   output logic                o_rd,
   output logic                o_wr,
   output logic [31:0]         o_offset,
   output logic                o_ack,
   output logic [C_DWIDTH-1:0] o_dbus
);

   logic                w_hit;
   logic                w_req;
   logic                r_busy;
   logic                r_ack;
   logic [C_DWIDTH-1:0] r_rdata;

   assign w_hit    = (i_addr >= C_BASEADDR) && (i_addr <= C_HIGHADDR);
   // r_busy holds off a second transfer while select stays high
   assign w_req    = i_select & w_hit & ~r_busy & ~r_ack;
   assign o_rd     = w_req & i_rnw;
   assign o_wr     = w_req & ~i_rnw;
   assign o_offset = i_addr - C_BASEADDR;
   assign o_ack    = r_ack;
   assign o_dbus   = r_ack ? r_rdata : '0;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_busy  <= 1'b0;
         r_ack   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_ack  <= w_req;
         r_busy <= i_select & (r_busy | w_req);
         if (w_req)
            r_rdata <= i_rnw ? i_rdata : '0;
      end
   end

endmodule

// File: rtl/opb_snapshot_regbank.sv
// opb_snapshot_regbank: OPB read-only bank of user channels captured
// continuously or on an armed trigger, with NEW flags and counters.
module opb_snapshot_regbank
   import opb_snapshot_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR   = 32'hFFFF_FFFF,
   parameter logic [31:0] C_HIGHADDR   = 32'h0000_0000,
   parameter int          C_OPB_AWIDTH = 32,
   parameter int          C_OPB_DWIDTH = 32,
   parameter int          C_NUM_CH     = 8,
   parameter int          C_DATA_WIDTH = 32,
   parameter              C_FAMILY     = "virtex6"
) (
   input  logic                             OPB_Clk,
   input  logic                             OPB_Rst_n,
   input  logic [0:C_OPB_AWIDTH-1]          OPB_ABus,
   input  logic [0:3]                       OPB_BE,
   input  logic [0:C_OPB_DWIDTH-1]          OPB_DBus,
   input  logic                             OPB_RNW,
   input  logic                             OPB_select,
   input  logic                             OPB_seqAddr,
   output logic [0:C_OPB_DWIDTH-1]          Sl_DBus,
   output logic                             Sl_xferAck,
   output logic                             Sl_errAck,
   output logic                             Sl_retry,
   output logic                             Sl_toutSup,
   input  logic [C_NUM_CH*C_DATA_WIDTH-1:0] user_data_in,
   input  logic [C_NUM_CH-1:0]              user_valid_in,
   input  logic                             user_trig
);

   logic                    w_rd, w_wr;
   logic [31:0]             w_off, w_wdata, w_rdata;
   logic                    w_ctrl_wr, w_arm, w_clr;
   logic                    w_armed, w_cap, w_miss, w_unused;
   logic [C_NUM_CH-1:0]     w_load, w_rdclr;
   logic                    r_mode;
   state_t                  r_state;
   logic [C_DATA_WIDTH-1:0] r_data [C_NUM_CH];
   logic [C_NUM_CH-1:0]     r_new;
   logic [31:0]             r_capcnt;
   logic [MISSED_W-1:0]     r_missed;

   opb_slave_decode #(
      .C_BASEADDR (C_BASEADDR),
      .C_HIGHADDR (C_HIGHADDR),
      .C_DWIDTH   (32)
   ) u_dec (
      .i_clk    (OPB_Clk),
      .i_rst_n  (OPB_Rst_n),
      .i_addr   (OPB_ABus),
      .i_select (OPB_select),
      .i_rnw    (OPB_RNW),
      .i_rdata  (w_rdata),
      .o_rd     (w_rd),
      .o_wr     (w_wr),
      .o_offset (w_off),
      .o_ack    (Sl_xferAck),
      .o_dbus   (Sl_DBus)
   );

   assign Sl_errAck  = 1'b0;
   assign Sl_retry   = 1'b0;
   assign Sl_toutSup = 1'b0;
   assign w_wdata    = OPB_DBus;
   assign w_unused   = ^{OPB_BE, OPB_seqAddr, w_wdata[28:0], |C_FAMILY};

   assign w_ctrl_wr = w_wr & (w_off == OFF_CTRL);
   assign w_arm     = w_ctrl_wr & w_wdata[CTRL_ARM];
   assign w_clr     = w_ctrl_wr & w_wdata[CTRL_CLR];
   assign w_armed   = r_mode & (r_state == ST_ARMED);
   assign w_load    = r_mode ? {C_NUM_CH{w_armed & user_trig}}
                             : user_valid_in;
   assign w_miss    = r_mode ? (user_trig & ~w_armed)
                             : |(user_valid_in & r_new);
   assign w_cap     = |w_load;

   always_comb begin
      w_rdata = '0;
      w_rdclr = '0;
      case (w_off)
         OFF_CTRL:   w_rdata[CTRL_MODE] = r_mode;
         OFF_STATUS: w_rdata = {r_state, 30'd0} | 32'(r_new);
         OFF_CAPCNT: w_rdata = r_capcnt;
         OFF_MISSED: w_rdata = 32'(r_missed);
         default:    ;
      endcase
      for (int i = 0; i < C_NUM_CH; i++)
         if (w_off == OFF_DATA + 32'(4 * i)) begin
            w_rdata    = 32'(r_data[i]);
            w_rdclr[i] = w_rd;
         end
   end

   // Trigger is judged against the current state, so ARM+trig in
   // CAPTURED lands in ARMED with the trigger counted as missed.
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         r_mode  <= 1'b0;
         r_state <= ST_IDLE;
      end else if (w_ctrl_wr) begin
         r_mode  <= w_wdata[CTRL_MODE];
         r_state <= (w_arm & w_wdata[CTRL_MODE]) ? ST_ARMED : ST_IDLE;
      end else if (w_armed & user_trig) begin
         r_state <= ST_CAPTURED;
      end
   end

   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         for (int i = 0; i < C_NUM_CH; i++)
            r_data[i] <= '0;
      end else begin
         for (int i = 0; i < C_NUM_CH; i++)
            if (w_load[i])
               r_data[i] <= user_data_in[i*C_DATA_WIDTH +: C_DATA_WIDTH];
      end
   end

   // A capture beats a same-cycle read-clear; CLR beats everything.
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         r_new    <= '0;
         r_capcnt <= '0;
         r_missed <= '0;
      end else if (w_clr) begin
         r_new    <= '0;
         r_capcnt <= '0;
         r_missed <= '0;
      end else begin
         r_new <= (r_new & ~w_rdclr) | w_load;
         if (w_cap)
            r_capcnt <= r_capcnt + 32'd1;
         if (w_miss && (r_missed != '1))
            r_missed <= r_missed + MISSED_W'(1);
      end
   end

endmodule
